// File: rtl/cr16_pkg.sv
// Shared CR16 register-file constants and the register index type.
package cr16_pkg;
  localparam int CR16_REG_WIDTH  = 16;
  localparam int CR16_FILE_WIDTH = 16;
  localparam int CR16_ADDR_WIDTH = 4;

  typedef logic [CR16_ADDR_WIDTH-1:0] reg_idx_t;
endpackage

// File: rtl/load_tag_fifo.sv
// In-order FIFO of load destination indices.
// Pushes are dropped when the FIFO is full, and pops are dropped when it is empty.
module load_tag_fifo
  import cr16_pkg::*;
#(
  parameter int P_DEPTH      = 2,
  parameter int P_ADDR_WIDTH = CR16_ADDR_WIDTH
) (
  input  logic                    gclk,
  input  logic                    grst,
  input  logic                    push,
  input  logic [P_ADDR_WIDTH-1:0] push_tag,
  input  logic                    pop,
  output logic [P_ADDR_WIDTH-1:0] head,
  output logic                    full,
  output logic                    empty
);
  localparam int PW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam int CW = $clog2(P_DEPTH + 1);

  logic [P_ADDR_WIDTH-1:0] mem [P_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           cnt;
  logic                    push_ok, pop_ok;

  // Pointers wrap explicitly because P_DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(P_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(P_DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge gclk or posedge grst)
    if (grst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end

  always_ff @(posedge gclk)
    if (push_ok) mem[wr_ptr] <= push_tag;
endmodule

// File: rtl/reg_writeback.sv
// CR16 write-back stage: merges ALU results and in-order load returns into one
// registered register-file write per cycle, and keeps a pending-load busy scoreboard.
module reg_writeback
  import cr16_pkg::*;
#(
  parameter int P_REG_WIDTH  = CR16_REG_WIDTH,
  parameter int P_FILE_WIDTH = CR16_FILE_WIDTH,
  parameter int P_ADDR_WIDTH = CR16_ADDR_WIDTH,
  parameter int P_LOAD_DEPTH = 2
) (
  input  logic                    I_CLK,
  input  logic                    I_RESET,
  input  logic                    I_ALU_VALID,
  output logic                    O_ALU_READY,
  input  logic [P_ADDR_WIDTH-1:0] I_ALU_ADDR,
  input  logic [P_REG_WIDTH-1:0]  I_ALU_DATA,
  input  logic                    I_LOAD_ISSUE,
  output logic                    O_LOAD_READY,
  input  logic [P_ADDR_WIDTH-1:0] I_LOAD_ADDR,
  input  logic                    I_MEM_VALID,
  input  logic [P_REG_WIDTH-1:0]  I_MEM_DATA,
  output logic [P_REG_WIDTH-1:0]  O_REG_BUS,
  output logic [P_FILE_WIDTH-1:0] O_REG_ENABLE,
  output logic [P_FILE_WIDTH-1:0] O_BUSY,
  output logic                    O_ERR
);
  logic                    fifo_full, fifo_empty;
  logic [P_ADDR_WIDTH-1:0] fifo_head;
  logic                    alu_fire, load_fire, mem_pop;

  logic                    hold_vld;
  logic [P_ADDR_WIDTH-1:0] hold_addr;
  logic [P_REG_WIDTH-1:0]  hold_data;

  logic                    sel_vld, sel_mem;
  logic [P_ADDR_WIDTH-1:0] sel_addr;
  logic [P_REG_WIDTH-1:0]  sel_data;

  logic                    clr_vld;
  logic [P_ADDR_WIDTH-1:0] clr_tag;

  // A busy destination stalls an ALU write so that it cannot overtake the older load.
  assign O_ALU_READY  = ~hold_vld & ~O_BUSY[I_ALU_ADDR];
  assign O_LOAD_READY = ~fifo_full & ~O_BUSY[I_LOAD_ADDR];
  assign alu_fire     = I_ALU_VALID & O_ALU_READY;
  assign load_fire    = I_LOAD_ISSUE & O_LOAD_READY;
  assign mem_pop      = I_MEM_VALID & ~fifo_empty;

  load_tag_fifo #(
    .P_DEPTH      (P_LOAD_DEPTH),
    .P_ADDR_WIDTH (P_ADDR_WIDTH)
  ) u_tag_fifo (
    .gclk     (I_CLK),
    .grst     (I_RESET),
    .push     (load_fire),
    .push_tag (I_LOAD_ADDR),
    .pop      (mem_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Write-slot priority: memory return, then held ALU result, then new ALU handshake.
  always_comb begin
    sel_vld  = 1'b0;
    sel_mem  = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    if (mem_pop) begin
      sel_vld  = 1'b1;
      sel_mem  = 1'b1;
      sel_addr = fifo_head;
      sel_data = I_MEM_DATA;
    end else if (hold_vld) begin
      sel_vld  = 1'b1;
      sel_addr = hold_addr;
      sel_data = hold_data;
    end else if (alu_fire) begin
      sel_vld  = 1'b1;
      sel_addr = I_ALU_ADDR;
      sel_data = I_ALU_DATA;
    end
  end

  // alu_fire implies hold is empty, so capture and drain never coincide.
  always_ff @(posedge I_CLK or posedge I_RESET)
    if (I_RESET) begin
      hold_vld  <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
    end else if (alu_fire && mem_pop) begin
      hold_vld  <= 1'b1;
      hold_addr <= I_ALU_ADDR;
      hold_data <= I_ALU_DATA;
    end else if (hold_vld && !mem_pop) begin
      hold_vld  <= 1'b0;
    end

  always_ff @(posedge I_CLK or posedge I_RESET)
    if (I_RESET) begin
      O_REG_ENABLE <= '0;
      O_REG_BUS    <= '0;
      clr_vld      <= 1'b0;
      clr_tag      <= '0;
      O_ERR        <= 1'b0;
    end else begin
      O_REG_ENABLE <= sel_vld ? ({{(P_FILE_WIDTH-1){1'b0}}, 1'b1} << sel_addr) : '0;
      if (sel_vld) O_REG_BUS <= sel_data;
      clr_vld      <= sel_mem;
      clr_tag      <= sel_addr;
      if (I_MEM_VALID && fifo_empty) O_ERR <= 1'b1;
    end

  // Busy stays set through the enable cycle and clears on the edge that ends it.
  always_ff @(posedge I_CLK or posedge I_RESET)
    if (I_RESET) O_BUSY <= '0;
    else
      for (int i = 0; i < P_FILE_WIDTH; i++) begin
        if (load_fire && I_LOAD_ADDR == P_ADDR_WIDTH'(i))  O_BUSY[i] <= 1'b1;
        else if (clr_vld && clr_tag == P_ADDR_WIDTH'(i))   O_BUSY[i] <= 1'b0;
      end
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: ALU writes, load round trips, collisions,
// FIFO limits, hazards and mid-operation reset.
module tb_reg_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_addr;
  logic [15:0] alu_data;
  logic        load_issue, load_ready;
  logic [3:0]  load_addr;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic [15:0] reg_bus, reg_en, busy;
  logic        err;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  reg_writeback dut (
    .I_CLK        (clk),
    .I_RESET      (rst),
    .I_ALU_VALID  (alu_valid),
    .O_ALU_READY  (alu_ready),
    .I_ALU_ADDR   (alu_addr),
    .I_ALU_DATA   (alu_data),
    .I_LOAD_ISSUE (load_issue),
    .O_LOAD_READY (load_ready),
    .I_LOAD_ADDR  (load_addr),
    .I_MEM_VALID  (mem_valid),
    .I_MEM_DATA   (mem_data),
    .O_REG_BUS    (reg_bus),
    .O_REG_ENABLE (reg_en),
    .O_BUSY       (busy),
    .O_ERR        (err)
  );

  // Advance to the start of the next cycle (1 time unit after the rising edge).
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    load_issue = 0; load_addr = 0; mem_valid = 0; mem_data = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    cyc(); cyc(); #1;
    total++; if (reg_en !== 16'h0) begin bad++; $display("FAIL rst_en act=%h req=0000", reg_en); end
    total++; if (reg_bus !== 16'h0) begin bad++; $display("FAIL rst_bus act=%h req=0000", reg_bus); end
    total++; if (busy !== 16'h0) begin bad++; $display("FAIL rst_busy act=%h req=0000", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err act=%b req=0", err); end
    total++; if ({alu_ready, load_ready} !== 2'b11) begin bad++; $display("FAIL rst_ready act=%b req=11", {alu_ready, load_ready}); end
    rst = 0;
    cyc();
  endtask

  task automatic test_alu_only();
    alu_valid = 1; alu_addr = 3; alu_data = 16'h1234; #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL alu_ready act=%b req=1", alu_ready); end
    cyc(); idle(); #1;
    total++; if (reg_en !== 16'h0008) begin bad++; $display("FAIL alu_en act=%h req=0008", reg_en); end
    total++; if (reg_bus !== 16'h1234) begin bad++; $display("FAIL alu_bus act=%h req=1234", reg_bus); end
    cyc(); #1;
    total++; if (reg_en !== 16'h0) begin bad++; $display("FAIL alu_en_once act=%h req=0000", reg_en); end
    total++; if (reg_bus !== 16'h1234) begin bad++; $display("FAIL alu_bus_hold act=%h req=1234", reg_bus); end
    cyc();
  endtask

  task automatic test_load_round_trip();
    load_issue = 1; load_addr = 5; #1;
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL ld_ready act=%b req=1", load_ready); end
    cyc(); idle(); #1;
    total++; if (busy !== 16'h0020) begin bad++; $display("FAIL ld_busy1 act=%h req=0020", busy); end
    cyc(); cyc(); #1;
    total++; if (busy !== 16'h0020 || reg_en !== 16'h0) begin bad++; $display("FAIL ld_busy3 act=%h/%h req=0020/0000", busy, reg_en); end
    cyc(); mem_valid = 1; mem_data = 16'hBEEF;
    cyc(); idle(); #1;
    total++; if (reg_en !== 16'h0020) begin bad++; $display("FAIL ld_en act=%h req=0020", reg_en); end
    total++; if (reg_bus !== 16'hBEEF) begin bad++; $display("FAIL ld_bus act=%h req=beef", reg_bus); end
    total++; if (busy !== 16'h0020) begin bad++; $display("FAIL ld_busy5 act=%h req=0020", busy); end
    cyc(); #1;
    total++; if (busy !== 16'h0 || reg_en !== 16'h0) begin bad++; $display("FAIL ld_busy6 act=%h/%h req=0000/0000", busy, reg_en); end
    cyc();
  endtask

  task automatic test_collision();
    load_issue = 1; load_addr = 2;
    cyc(); idle();
    cyc();
    alu_valid = 1; alu_addr = 1; alu_data = 16'h1111;
    mem_valid = 1; mem_data = 16'h2222; #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL col_ready0 act=%b req=1", alu_ready); end
    cyc(); idle(); alu_addr = 1; #1;
    total++; if (reg_en !== 16'h0004 || reg_bus !== 16'h2222) begin bad++; $display("FAIL col_mem act=%h/%h req=0004/2222", reg_en, reg_bus); end
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL col_ready1 act=%b req=0", alu_ready); end
    cyc(); #1;
    total++; if (reg_en !== 16'h0002 || reg_bus !== 16'h1111) begin bad++; $display("FAIL col_hold act=%h/%h req=0002/1111", reg_en, reg_bus); end
    total++; if (alu_ready !== 1'b1 || busy !== 16'h0) begin bad++; $display("FAIL col_ready2 act=%b/%h req=1/0000", alu_ready, busy); end
    cyc();
  endtask

  task automatic test_fifo_full();
    load_issue = 1; load_addr = 4;
    cyc(); load_addr = 6; #1;
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL ff_ready2 act=%b req=1", load_ready); end
    cyc(); load_addr = 8; #1;
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL ff_full act=%b req=0", load_ready); end
    cyc(); mem_valid = 1; mem_data = 16'hAAAA; #1;
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL ff_full_pop act=%b req=0", load_ready); end
    cyc(); mem_valid = 0; #1;
    total++; if (reg_en !== 16'h0010 || reg_bus !== 16'hAAAA) begin bad++; $display("FAIL ff_first act=%h/%h req=0010/aaaa", reg_en, reg_bus); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL ff_reready act=%b req=1", load_ready); end
    cyc(); load_issue = 0; mem_valid = 1; mem_data = 16'hBBBB;
    cyc(); mem_valid = 0; #1;
    total++; if (reg_en !== 16'h0040 || reg_bus !== 16'hBBBB) begin bad++; $display("FAIL ff_second act=%h/%h req=0040/bbbb", reg_en, reg_bus); end
    total++; if (busy !== 16'h0140) begin bad++; $display("FAIL ff_busy act=%h req=0140", busy); end
    cyc(); mem_valid = 1; mem_data = 16'h8888;
    cyc(); idle(); #1;
    total++; if (reg_en !== 16'h0100 || reg_bus !== 16'h8888) begin bad++; $display("FAIL ff_third act=%h/%h req=0100/8888", reg_en, reg_bus); end
    cyc(); #1;
    total++; if (busy !== 16'h0) begin bad++; $display("FAIL ff_drain act=%h req=0000", busy); end
    cyc();
  endtask

  task automatic test_back_to_back();
    alu_valid = 1; alu_addr = 0; alu_data = 16'h0A0A;
    cyc(); alu_addr = 9; alu_data = 16'h0909; #1;
    total++; if (reg_en !== 16'h0001 || reg_bus !== 16'h0A0A) begin bad++; $display("FAIL b2b_r0 act=%h/%h req=0001/0a0a", reg_en, reg_bus); end
    cyc(); alu_addr = 15; alu_data = 16'hF0F0; #1;
    total++; if (reg_en !== 16'h0200 || reg_bus !== 16'h0909) begin bad++; $display("FAIL b2b_r9 act=%h/%h req=0200/0909", reg_en, reg_bus); end
    cyc(); idle(); #1;
    total++; if (reg_en !== 16'h8000 || reg_bus !== 16'hF0F0) begin bad++; $display("FAIL b2b_r15 act=%h/%h req=8000/f0f0", reg_en, reg_bus); end
    cyc(); #1;
    total++; if (reg_en !== 16'h0) begin bad++; $display("FAIL b2b_idle act=%h req=0000", reg_en); end
    cyc();
  endtask

  task automatic test_hazard();
    load_issue = 1; load_addr = 7;
    cyc(); load_issue = 0; alu_valid = 1; alu_addr = 7; alu_data = 16'h7777; #1;
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL hz_stall1 act=%b req=0", alu_ready); end
    cyc(); mem_valid = 1; mem_data = 16'h0707; #1;
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL hz_stall2 act=%b req=0", alu_ready); end
    cyc(); mem_valid = 0; load_issue = 1; load_addr = 7; #1;
    total++; if (reg_en !== 16'h0080 || reg_bus !== 16'h0707) begin bad++; $display("FAIL hz_mem act=%h/%h req=0080/0707", reg_en, reg_bus); end
    total++; if ({alu_ready, load_ready} !== 2'b00) begin bad++; $display("FAIL hz_sameedge act=%b req=00", {alu_ready, load_ready}); end
    cyc(); load_issue = 0; #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL hz_release act=%b req=1", alu_ready); end
    cyc(); idle(); #1;
    total++; if (reg_en !== 16'h0080 || reg_bus !== 16'h7777) begin bad++; $display("FAIL hz_alu act=%h/%h req=0080/7777", reg_en, reg_bus); end
    total++; if (busy !== 16'h0 || err !== 1'b0) begin bad++; $display("FAIL hz_clean act=%h/%b req=0000/0", busy, err); end
    cyc(); mem_valid = 1; mem_data = 16'hDEAD;
    cyc(); idle(); #1;
    total++; if (reg_en !== 16'h0 || err !== 1'b1) begin bad++; $display("FAIL hz_err act=%h/%b req=0000/1", reg_en, err); end
    cyc(); cyc(); #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL hz_err_sticky act=%b req=1", err); end
    cyc();
  endtask

  task automatic test_reset_mid();
    load_issue = 1; load_addr = 10;
    cyc(); load_addr = 11; mem_valid = 1; mem_data = 16'hA0A0;
    alu_valid = 1; alu_addr = 3; alu_data = 16'h3333;
    cyc(); idle(); #1;
    total++; if (busy !== 16'h0C00 || reg_en !== 16'h0400) begin bad++; $display("FAIL rm_setup act=%h/%h req=0c00/0400", busy, reg_en); end
    rst = 1; #1;
    total++; if (reg_en !== 16'h0 || reg_bus !== 16'h0 || busy !== 16'h0 || err !== 1'b0) begin bad++; $display("FAIL rm_async en=%h bus=%h busy=%h err=%b req=all 0", reg_en, reg_bus, busy, err); end
    cyc(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      total++; if (reg_en !== 16'h0 || busy !== 16'h0) begin bad++; $display("FAIL rm_stale%0d act=%h/%h req=0000/0000", i, reg_en, busy); end
    end
    mem_valid = 1; mem_data = 16'h5555;
    cyc(); idle(); #1;
    total++; if (reg_en !== 16'h0 || err !== 1'b1) begin bad++; $display("FAIL rm_fifo_empty act=%h/%b req=0000/1", reg_en, err); end
    cyc();
  endtask

  initial begin
    idle(); rst = 1;
    #2;
    test_reset();
    test_alu_only();
    test_load_round_trip();
    test_collision();
    test_fifo_full();
    test_back_to_back();
    test_hazard();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
